bus_resp_collector: RTL and testbench
=====================================

# bus_resp_collector

Return-path companion to the peripheral bus address decoder. It takes the one-hot slave chip-selects and the address-error flag produced on the request path, and tracks the outstanding transfer. It then steers the selected slave's data, ack and error back to the single bus master as a registered one-cycle response. It also converts unmapped addresses and unresponsive slaves into error terminations, so the master never hangs.

## Interface
Parameters:
- SLAVE_NUMBER, 8: number of slave ports; equals `SLAVE_NUMBER from BusConfig.v.
- DATA_WIDTH, 32: read data width.
- TIMEOUT, 255: maximum cycles spent waiting in WAIT before an error is forced; range 1..65535.

Ports:
- clk_i  in  1  single bus clock.
- rst_n_i  in  1  reset; asynchronous and active-low.
- cyc_i  in  1  master cycle valid.
- stb_i  in  1  master strobe.
- cs_i  in  SLAVE_NUMBER  one-hot chip-select from the address decoder, already gated by stb.
- adr_err_i  in  1  decoder reports that no slave matched the address.
- slv_dat_i  in  SLAVE_NUMBER*DATA_WIDTH  slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- slv_ack_i  in  SLAVE_NUMBER  per-slave ack.
- slv_err_i  in  SLAVE_NUMBER  per-slave error.
- dat_o  out  DATA_WIDTH  registered read data to the master.
- ack_o  out  1  one-cycle successful-termination pulse.
- err_o  out  1  one-cycle error-termination pulse.
- busy_o  out  1  high while in the WAIT or RESP state.
- timeout_o  out  1  sticky flag set by a watchdog expiry; cleared only by reset.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. Reset enters IDLE.
- IDLE, with cyc_i&stb_i high:
  - If adr_err_i is high, go to RESP with an error termination.
  - Otherwise latch cs_i into sel_q, clear the watchdog and go to WAIT.
  - If more than one bit of cs_i is set, keep only the lowest-index bit.
- WAIT: only slave index sel_q is observed. Acks and errors from other slaves are ignored.
  - slv_err_i[sel] high: go to RESP with an error termination. Error has priority over a simultaneous ack.
  - slv_ack_i[sel] high: capture that slave's data into dat_o and go to RESP with an ack termination.
  - Watchdog equals TIMEOUT with no ack or error from the selected slave: go to RESP with an error termination and set timeout_o.
  - cyc_i low: abort and return to IDLE. No ack or error is issued, and dat_o is unchanged.
- RESP: exactly one of ack_o or err_o is high for this single cycle; then return to IDLE unconditionally. Any strobe present during RESP is ignored. A new transfer is accepted only from IDLE.
- dat_o holds its last captured value; it is not updated on an error termination.

## Timing
- Reset values: dat_o=0, ack_o=0, err_o=0, busy_o=0, timeout_o=0, sel_q=0, watchdog=0.
- Decode error latency: strobe seen in IDLE at cycle 0; err_o high in cycle 1.
- Normal transfer latency: strobe at cycle 0; WAIT from cycle 1; slave ack at cycle k≥1; ack_o and dat_o valid at cycle k+1.
- Timeout:
  - The watchdog increments once per WAIT cycle and saturates; its width is clog2(TIMEOUT+1).
  - With no slave response, err_o rises in cycle TIMEOUT+2 after the strobe.
- Back-to-back transfers: minimum 3 cycles per transfer (IDLE, WAIT, RESP).
- Reset asserted mid-transfer: all outputs return to their reset values immediately, with no response pulse.

## Structure
- BusConfig.v gains: the TIMEOUT default, the state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and a DATA_WIDTH define. It continues to provide SLAVE_NUMBER.
- One sub-module, bus_timeout_counter, holds the watchdog.
  - Inputs: clear, enable.
  - Output: expired.
  - The TIMEOUT parameter passes through.
- The data mux is a one-hot AND-OR over slv_dat_i using sel_q; no priority encoder sits on the data path.

## Test plan
- Slave 3 acks 2 cycles after the strobe with data 0xDEADBEEF: ack_o pulses 1 cycle at cycle 3, dat_o=0xDEADBEEF, err_o=0.
- adr_err_i=1 with cs_i=0: err_o pulses at cycle 1, ack_o=0, and dat_o keeps its previous value.
- TIMEOUT=4 and slave 1 never responds: err_o at cycle 6, timeout_o stays high afterwards, and busy_o falls after the RESP cycle.
- Selected slave 2 drives slv_ack_i and slv_err_i together, while slave 5 acks in the same cycles: only err_o pulses, and slave 5 is ignored.
- cyc_i dropped in the second WAIT cycle: no ack_o or err_o, IDLE the next cycle, and a new strobe is accepted immediately.
- rst_n_i asserted while in WAIT: all outputs read 0 within the same cycle; after release, a normal transfer completes correctly.

Source files
------------

// File: rtl/bus_resp_collector_pkg.sv
// Shared configuration for the bus response collector: default sizes,
// watchdog limit and FSM state encoding.
package bus_resp_collector_pkg;

  localparam int BRC_SLAVE_NUMBER = 8;
  localparam int BRC_DATA_WIDTH   = 32;
  localparam int BRC_TIMEOUT      = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bus_resp_collector_timeout.sv
// Saturating watchdog: counts enabled cycles from a clear and flags when
// the count has reached TIMEOUT.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/bus_resp_collector.sv
// Return-path collector: tracks one outstanding transfer and returns the
// selected slave's data/ack/err, or a forced error, as a one-cycle response.
module bus_resp_collector
  import bus_resp_collector_pkg::*;
#(
  parameter int SLAVE_NUMBER = BRC_SLAVE_NUMBER,
  parameter int DATA_WIDTH   = BRC_DATA_WIDTH,
  parameter int TIMEOUT      = BRC_TIMEOUT
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             cyc_i,
  input  logic                             stb_i,
  input  logic [SLAVE_NUMBER-1:0]          cs_i,
  input  logic                             adr_err_i,
  input  logic [SLAVE_NUMBER*DATA_WIDTH-1:0] slv_dat_i,
  input  logic [SLAVE_NUMBER-1:0]          slv_ack_i,
  input  logic [SLAVE_NUMBER-1:0]          slv_err_i,
  output logic [DATA_WIDTH-1:0]            dat_o,
  output logic                             ack_o,
  output logic                             err_o,
  output logic                             busy_o,
  output logic                             timeout_o
);

  state_t                  state;
  logic [SLAVE_NUMBER-1:0] sel_q;
  logic [SLAVE_NUMBER-1:0] cs_lowest;
  logic [DATA_WIDTH-1:0]   mux_dat;
  logic                    sel_ack;
  logic                    sel_err;
  logic                    start;
  logic                    expired;

  // Two's-complement trick isolates the lowest set chip-select bit.
  assign cs_lowest = cs_i & (~cs_i + SLAVE_NUMBER'(1));
  assign start     = (state == ST_IDLE) && cyc_i && stb_i;
  assign sel_ack   = |(slv_ack_i & sel_q);
  assign sel_err   = |(slv_err_i & sel_q);

  always_comb begin
    mux_dat = '0;
    for (int k = 0; k < SLAVE_NUMBER; k++) begin
      mux_dat = mux_dat | (slv_dat_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_q[k]}});
    end
  end

  bus_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .clear  (start),
    .enable (state == ST_WAIT),
    .expired(expired)
  );

  // A master abort wins over anything the slave does in the same cycle,
  // so a dropped cycle never produces a stray termination.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      dat_o     <= '0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cyc_i && stb_i) begin
            busy_o <= 1'b1;
            if (adr_err_i) begin
              err_o <= 1'b1;
              state <= ST_RESP;
            end else begin
              sel_q <= cs_lowest;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!cyc_i) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (sel_err) begin
            err_o <= 1'b1;
            state <= ST_RESP;
          end else if (sel_ack) begin
            dat_o <= mux_dat;
            ack_o <= 1'b1;
            state <= ST_RESP;
          end else if (expired) begin
            err_o     <= 1'b1;
            timeout_o <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_resp_collector.sv
// Directed self-checking bench for bus_resp_collector; status vectors are
// {ack_o, err_o, busy_o, timeout_o}.
module tb_bus_resp_collector;

  localparam int SN = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cyc;
  logic             stb;
  logic [SN-1:0]    cs;
  logic             adr_err;
  logic [SN*DW-1:0] slv_dat;
  logic [SN-1:0]    slv_ack;
  logic [SN-1:0]    slv_err;
  logic [DW-1:0]    dat;
  logic             ack;
  logic             err;
  logic             busy;
  logic             tmo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_resp_collector #(
    .SLAVE_NUMBER(SN),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .cyc_i    (cyc),
    .stb_i    (stb),
    .cs_i     (cs),
    .adr_err_i(adr_err),
    .slv_dat_i(slv_dat),
    .slv_ack_i(slv_ack),
    .slv_err_i(slv_err),
    .dat_o    (dat),
    .ack_o    (ack),
    .err_o    (err),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle_inputs;
    cyc = 0; stb = 0; cs = '0; adr_err = 0; slv_ack = '0; slv_err = '0;
  endtask

  task strobe(input logic [SN-1:0] sel, input logic aerr);
    cyc = 1; stb = 1; cs = sel; adr_err = aerr;
  endtask

  task test_reset;
    idle_inputs();
    slv_dat = '0;
    rst_n = 0;
    tick(); tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL reset_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
    checks++;
    if (dat !== 32'h0) begin
      failures++; $display("FAIL reset_dat got=%h want=%h", dat, 32'h0);
    end
    rst_n = 1;
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL reset_release_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
  endtask

  task test_normal;
    slv_dat[2*DW +: DW] = 32'h12345678;
    slv_dat[3*DW +: DW] = 32'hDEADBEEF;
    strobe(8'h08, 0);
    tick();
    stb = 0; cs = '0;
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0010) begin
      failures++; $display("FAIL normal_c1_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0010);
    end
    tick();
    slv_ack = 8'h08;
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0010) begin
      failures++; $display("FAIL normal_c2_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0010);
    end
    tick();
    idle_inputs();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b1010) begin
      failures++; $display("FAIL normal_c3_status got=%b want=%b", {ack, err, busy, tmo}, 4'b1010);
    end
    checks++;
    if (dat !== 32'hDEADBEEF) begin
      failures++; $display("FAIL normal_c3_dat got=%h want=%h", dat, 32'hDEADBEEF);
    end
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL normal_c4_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
  endtask

  task test_decode_err;
    strobe(8'h00, 1);
    tick();
    idle_inputs();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0110) begin
      failures++; $display("FAIL decerr_c1_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0110);
    end
    checks++;
    if (dat !== 32'hDEADBEEF) begin
      failures++; $display("FAIL decerr_c1_dat got=%h want=%h", dat, 32'hDEADBEEF);
    end
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL decerr_c2_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
  endtask

  task test_multi_cs;
    slv_dat[3*DW +: DW] = 32'h33CC33CC;
    slv_dat[5*DW +: DW] = 32'h55AA55AA;
    strobe(8'h28, 0);
    tick();
    stb = 0; cs = '0;
    slv_ack = 8'h20;
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0010) begin
      failures++; $display("FAIL multics_c2_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0010);
    end
    slv_ack = 8'h08;
    tick();
    idle_inputs();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b1010) begin
      failures++; $display("FAIL multics_c3_status got=%b want=%b", {ack, err, busy, tmo}, 4'b1010);
    end
    checks++;
    if (dat !== 32'h33CC33CC) begin
      failures++; $display("FAIL multics_c3_dat got=%h want=%h", dat, 32'h33CC33CC);
    end
    tick();
  endtask

  task test_priority;
    slv_dat[2*DW +: DW] = 32'h22222222;
    strobe(8'h04, 0);
    tick();
    stb = 0; cs = '0;
    slv_ack = 8'h20;
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0010) begin
      failures++; $display("FAIL prio_c2_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0010);
    end
    slv_ack = 8'h24;
    slv_err = 8'h04;
    tick();
    idle_inputs();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0110) begin
      failures++; $display("FAIL prio_c3_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0110);
    end
    checks++;
    if (dat !== 32'h33CC33CC) begin
      failures++; $display("FAIL prio_c3_dat got=%h want=%h", dat, 32'h33CC33CC);
    end
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL prio_c4_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
  endtask

  task test_abort;
    slv_dat[0 +: DW] = 32'hCAFEF00D;
    strobe(8'h01, 0);
    tick();
    stb = 0; cs = '0;
    tick();
    cyc = 0;
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0010) begin
      failures++; $display("FAIL abort_c2_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0010);
    end
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL abort_c3_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
    checks++;
    if (dat !== 32'h33CC33CC) begin
      failures++; $display("FAIL abort_c3_dat got=%h want=%h", dat, 32'h33CC33CC);
    end
    strobe(8'h01, 0);
    tick();
    stb = 0; cs = '0;
    slv_ack = 8'h01;
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0010) begin
      failures++; $display("FAIL abort_restart_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0010);
    end
    tick();
    idle_inputs();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b1010) begin
      failures++; $display("FAIL abort_restart_ack got=%b want=%b", {ack, err, busy, tmo}, 4'b1010);
    end
    checks++;
    if (dat !== 32'hCAFEF00D) begin
      failures++; $display("FAIL abort_restart_dat got=%h want=%h", dat, 32'hCAFEF00D);
    end
    tick();
  endtask

  task test_timeout;
    strobe(8'h02, 0);
    tick();
    stb = 0; cs = '0;
    for (int c = 1; c <= TO + 1; c++) begin
      checks++;
      if ({ack, err, busy, tmo} !== 4'b0010) begin
        failures++; $display("FAIL timeout_wait_c%0d got=%b want=%b", c, {ack, err, busy, tmo}, 4'b0010);
      end
      tick();
    end
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0111) begin
      failures++; $display("FAIL timeout_c6_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0111);
    end
    checks++;
    if (dat !== 32'hCAFEF00D) begin
      failures++; $display("FAIL timeout_c6_dat got=%h want=%h", dat, 32'hCAFEF00D);
    end
    idle_inputs();
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0001) begin
      failures++; $display("FAIL timeout_c7_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0001);
    end
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0001) begin
      failures++; $display("FAIL timeout_sticky got=%b want=%b", {ack, err, busy, tmo}, 4'b0001);
    end
  endtask

  task test_reset_mid_wait;
    strobe(8'h08, 0);
    tick();
    stb = 0; cs = '0;
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0011) begin
      failures++; $display("FAIL rstmid_wait_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0011);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_async_status got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
    checks++;
    if (dat !== 32'h0) begin
      failures++; $display("FAIL rstmid_async_dat got=%h want=%h", dat, 32'h0);
    end
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
    slv_dat[6*DW +: DW] = 32'h0BADCAFE;
    strobe(8'h40, 0);
    tick();
    stb = 0; cs = '0;
    slv_ack = 8'h40;
    tick();
    idle_inputs();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b1010) begin
      failures++; $display("FAIL rstmid_after_status got=%b want=%b", {ack, err, busy, tmo}, 4'b1010);
    end
    checks++;
    if (dat !== 32'h0BADCAFE) begin
      failures++; $display("FAIL rstmid_after_dat got=%h want=%h", dat, 32'h0BADCAFE);
    end
    tick();
    checks++;
    if ({ack, err, busy, tmo} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_after_idle got=%b want=%b", {ack, err, busy, tmo}, 4'b0000);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_decode_err();
    test_multi_cs();
    test_priority();
    test_abort();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
